// File: rtl/stdp_update_scheduler.sv
// STDP update scheduler: timestamps pre/post spikes, marks LTP/LTD work per synapse and
// serialises the resulting read-modify-write updates through one shared weight-memory port.
module stdp_update_scheduler #(
    parameter int unsigned NUM_PRE = 4,
    parameter int unsigned TW      = 4,
    parameter int unsigned WW      = 4,
    parameter int unsigned WIN     = 8,
    parameter int unsigned AW      = $clog2(NUM_PRE)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [NUM_PRE-1:0] pre_spike,
    input  logic               post_spike,
    output logic               mem_req,
    output logic               mem_we,
    output logic [AW-1:0]      mem_addr,
    output logic [WW-1:0]      mem_wdata,
    input  logic               mem_gnt,
    input  logic [WW-1:0]      mem_rdata,
    output logic               busy,
    output logic               upd_done,
    output logic [7:0]         drop_cnt
);

    localparam logic [TW-1:0] TMAX  = {TW{1'b1}};
    localparam logic [WW-1:0] WMAX  = {WW{1'b1}};
    localparam logic [TW-1:0] WIN_T = TW'(WIN);

    typedef enum logic [1:0] {StIdle, StRd, StWr} state_e;

    state_e                      state_q, state_d;
    logic [NUM_PRE-1:0][TW-1:0]  pre_t_q, pre_t_d;
    logic [TW-1:0]               post_t_q, post_t_d;
    logic [NUM_PRE-1:0]          ltp_q, ltp_d, ltd_q, ltd_d;
    logic [NUM_PRE-1:0]          ltp_set, ltd_set, ltp_clr, ltd_clr;
    logic [AW-1:0]               rr_ptr_q, rr_ptr_d;
    logic [AW-1:0]               idx_q, idx_d;
    logic                        dir_q, dir_d;
    logic [WW-1:0]               wdata_q, wdata_d;
    logic                        upd_q, upd_d;
    logic [7:0]                  drop_q, drop_d;
    logic [AW:0]                 drop_sum;
    logic [8:0]                  drop_ext;
    logic [NUM_PRE-1:0]          pending;
    logic [AW-1:0]               cand, sel;
    logic                        found;

    // Spike timers: zero on a spike, otherwise count up and stick at TMAX.
    always_comb begin
        pre_t_d = pre_t_q;
        for (int i = 0; i < NUM_PRE; i++) begin
            if (pre_spike[i])             pre_t_d[i] = '0;
            else if (pre_t_q[i] != TMAX)  pre_t_d[i] = pre_t_q[i] + TW'(1);
        end
        post_t_d = post_t_q;
        if (post_spike)               post_t_d = '0;
        else if (post_t_q != TMAX)    post_t_d = post_t_q + TW'(1);
    end

    // Event capture; a set on a bit being cleared this cycle wins and is not a drop.
    always_comb begin
        drop_sum = '0;
        for (int i = 0; i < NUM_PRE; i++) begin
            ltp_set[i] = post_spike && !pre_spike[i] && (pre_t_q[i] < WIN_T);
            ltd_set[i] = pre_spike[i] && !post_spike && (post_t_q < WIN_T);
            if (ltp_set[i] && ltp_q[i] && !ltp_clr[i]) drop_sum = drop_sum + (AW+1)'(1);
            if (ltd_set[i] && ltd_q[i] && !ltd_clr[i]) drop_sum = drop_sum + (AW+1)'(1);
        end
        ltp_d    = (ltp_q & ~ltp_clr) | ltp_set;
        ltd_d    = (ltd_q & ~ltd_clr) | ltd_set;
        drop_ext = {1'b0, drop_q} + 9'(drop_sum);
        drop_d   = drop_ext[8] ? 8'hFF : drop_ext[7:0];
    end

    // Round-robin pick: first pending index at or after rr_ptr, wrapping.
    always_comb begin
        pending = ltp_q | ltd_q;
        found   = 1'b0;
        sel     = '0;
        cand    = '0;
        for (int k = 0; k < NUM_PRE; k++) begin
            cand = rr_ptr_q + AW'(k);
            if (!found && pending[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        dir_d    = dir_q;
        wdata_d  = wdata_q;
        rr_ptr_d = rr_ptr_q;
        ltp_clr  = '0;
        ltd_clr  = '0;
        upd_d    = 1'b0;
        case (state_q)
            StIdle: begin
                if (en && found) begin
                    if (ltp_q[sel] && ltd_q[sel]) begin
                        // Opposite updates cancel without touching memory.
                        ltp_clr[sel] = 1'b1;
                        ltd_clr[sel] = 1'b1;
                        rr_ptr_d     = sel + AW'(1);
                    end else begin
                        idx_d   = sel;
                        dir_d   = ltp_q[sel];
                        state_d = StRd;
                    end
                end
            end
            StRd: begin
                if (mem_gnt) begin
                    if (dir_q) wdata_d = (mem_rdata == WMAX) ? WMAX : mem_rdata + WW'(1);
                    else       wdata_d = (mem_rdata == '0) ? '0 : mem_rdata - WW'(1);
                    state_d = StWr;
                end
            end
            StWr: begin
                if (mem_gnt) begin
                    if (dir_q) ltp_clr[idx_q] = 1'b1;
                    else       ltd_clr[idx_q] = 1'b1;
                    upd_d    = 1'b1;
                    rr_ptr_d = idx_q + AW'(1);
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            pre_t_q  <= {NUM_PRE{TMAX}};
            post_t_q <= TMAX;
            ltp_q    <= '0;
            ltd_q    <= '0;
            rr_ptr_q <= '0;
            idx_q    <= '0;
            dir_q    <= 1'b0;
            wdata_q  <= '0;
            upd_q    <= 1'b0;
            drop_q   <= '0;
        end else begin
            state_q  <= state_d;
            pre_t_q  <= pre_t_d;
            post_t_q <= post_t_d;
            ltp_q    <= ltp_d;
            ltd_q    <= ltd_d;
            rr_ptr_q <= rr_ptr_d;
            idx_q    <= idx_d;
            dir_q    <= dir_d;
            wdata_q  <= wdata_d;
            upd_q    <= upd_d;
            drop_q   <= drop_d;
        end
    end

    assign mem_req   = (state_q != StIdle);
    assign mem_we    = (state_q == StWr);
    assign mem_addr  = idx_q;
    assign mem_wdata = wdata_q;
    assign busy      = (state_q != StIdle);
    assign upd_done  = upd_q;
    assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_stdp_update_scheduler.sv
// Scoreboard bench for stdp_update_scheduler: a small weight memory answers the port and
// every expected write (address, saturated data) is queued when the spikes are driven.
module tb_stdp_update_scheduler;

    localparam int NUM_PRE = 4;
    localparam int TW      = 4;
    localparam int WW      = 4;
    localparam int WIN     = 8;
    localparam int AW      = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b1;
    logic [3:0]    pre_spike = '0;
    logic          post_spike = 1'b0;
    logic          mem_req, mem_we, busy, upd_done;
    logic [AW-1:0] mem_addr;
    logic [WW-1:0] mem_wdata;
    logic          mem_gnt = 1'b0;
    logic [WW-1:0] mem_rdata = '0;
    logic [7:0]    drop_cnt;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [WW-1:0] wdata;
    } exp_t;

    exp_t          sb_q[$];
    logic [WW-1:0] wmem [NUM_PRE];
    logic [WW-1:0] wexp [NUM_PRE];
    int            n_checks = 0, n_errors = 0;
    int            rd_cnt = 0, wr_cnt = 0, upd_cnt = 0;
    int            stall_len = 0;
    bit            hold_wr = 1'b0, mon_en = 1'b0, exp_upd = 1'b0;
    int            base_rd, base_wr, base_upd;

    stdp_update_scheduler #(
        .NUM_PRE(NUM_PRE), .TW(TW), .WW(WW), .WIN(WIN), .AW(AW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .pre_spike(pre_spike), .post_spike(post_spike),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rdata(mem_rdata), .busy(busy), .upd_done(upd_done),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
        n_checks++;
        if (got !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp_v, $time);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [3:0] pre, input logic post);
        pre_spike  = pre;
        post_spike = post;
        cycle();
        pre_spike  = '0;
        post_spike = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sb_q.delete();
        exp_upd = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;
    endtask

    task automatic set_weight(input int a, input logic [WW-1:0] v);
        wmem[a] = v;
        wexp[a] = v;
    endtask

    task automatic push_upd(input int a, input bit up);
        logic [WW-1:0] v;
        v = wexp[a];
        if (up) v = (v == 4'hF) ? 4'hF : v + 4'd1;
        else    v = (v == 4'h0) ? 4'h0 : v - 4'd1;
        wexp[a] = v;
        sb_q.push_back('{addr: AW'(a), wdata: v});
    endtask

    task automatic wait_idle(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (sb_q.size() == 0 && !busy) break;
            cycle();
        end
        chk(tag, 32'(sb_q.size() == 0 && !busy), 32'd1);
        cycle();
        cycle();
    endtask

    task automatic mark();
        base_rd  = rd_cnt;
        base_wr  = wr_cnt;
        base_upd = upd_cnt;
    endtask

    // Memory model and monitor: decides grant for the current cycle, then checks the access.
    initial begin : monitor
        bit            g, stalled, wr_now;
        int            wait_cnt;
        logic [AW-1:0] s_addr;
        logic          s_we;
        logic [WW-1:0] s_wdata;
        exp_t          e;
        stalled  = 1'b0;
        wait_cnt = 0;
        forever begin
            @(negedge clk);
            g      = 1'b0;
            wr_now = 1'b0;
            if (mon_en) begin
                chk("upd_done", 32'(upd_done), 32'(exp_upd));
                if (upd_done) upd_cnt++;
                if (mem_req) begin
                    if (stalled) begin
                        chk("stable_addr", 32'(mem_addr), 32'(s_addr));
                        chk("stable_we", 32'(mem_we), 32'(s_we));
                        chk("stable_wdata", 32'(mem_wdata), 32'(s_wdata));
                    end
                    mem_rdata = wmem[mem_addr];
                    g = !(mem_we && hold_wr) && (wait_cnt >= stall_len);
                    if (g) begin
                        wait_cnt = 0;
                        if (mem_we) wr_cnt++;
                        else        rd_cnt++;
                        chk("sb_has_entry", 32'(sb_q.size() != 0), 32'd1);
                        if (sb_q.size() != 0) begin
                            if (!mem_we) begin
                                chk("rd_addr", 32'(mem_addr), 32'(sb_q[0].addr));
                            end else begin
                                e = sb_q.pop_front();
                                chk("wr_addr", 32'(mem_addr), 32'(e.addr));
                                chk("wr_data", 32'(mem_wdata), 32'(e.wdata));
                                wmem[mem_addr] = mem_wdata;
                                wr_now = 1'b1;
                            end
                        end
                    end else begin
                        wait_cnt++;
                    end
                    stalled = !g;
                    s_addr  = mem_addr;
                    s_we    = mem_we;
                    s_wdata = mem_wdata;
                end else begin
                    stalled  = 1'b0;
                    wait_cnt = 0;
                end
            end
            exp_upd = wr_now;
            mem_gnt = g;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d",
                 n_checks, n_errors);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NUM_PRE; i++) set_weight(i, 4'd0);
        rst_n = 1'b0;
        repeat (3) cycle();
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_upd_done", 32'(upd_done), 32'd0);
        chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // 1: LTP on synapse 1, weight 5 -> 6
        set_weight(1, 4'd5);
        mark();
        pulse(4'b0010, 1'b0);
        repeat (2) cycle();
        push_upd(1, 1'b1);
        pulse(4'b0000, 1'b1);
        wait_idle("t1_drain", 40);
        chk("t1_writes", 32'(wr_cnt - base_wr), 32'd1);
        chk("t1_upd", 32'(upd_cnt - base_upd), 32'd1);
        chk("t1_drop", 32'(drop_cnt), 32'd0);

        // 2: LTD saturates at 0, LTP saturates at 15
        do_reset();
        set_weight(2, 4'd0);
        mark();
        pulse(4'b0000, 1'b1);
        cycle();
        push_upd(2, 1'b0);
        pulse(4'b0100, 1'b0);
        wait_idle("t2_ltd_drain", 40);
        chk("t2_ltd_writes", 32'(wr_cnt - base_wr), 32'd1);
        do_reset();
        set_weight(3, 4'd15);
        mark();
        pulse(4'b1000, 1'b0);
        push_upd(3, 1'b1);
        pulse(4'b0000, 1'b1);
        wait_idle("t2_ltp_drain", 40);
        chk("t2_ltp_writes", 32'(wr_cnt - base_wr), 32'd1);

        // 3: window edge; pre_t seen at the post spike equals the number of idle cycles between
        do_reset();
        set_weight(0, 4'd4);
        mark();
        pulse(4'b0001, 1'b0);
        repeat (WIN) cycle();
        pulse(4'b0000, 1'b1);
        repeat (15) cycle();
        chk("t3_at_win_rd", 32'(rd_cnt - base_rd), 32'd0);
        do_reset();
        mark();
        pulse(4'b0001, 1'b0);
        repeat (WIN - 1) cycle();
        push_upd(0, 1'b1);
        pulse(4'b0000, 1'b1);
        wait_idle("t3_in_win_drain", 40);
        chk("t3_in_win_writes", 32'(wr_cnt - base_wr), 32'd1);
        do_reset();
        mark();
        pulse(4'b0001, 1'b1);
        repeat (15) cycle();
        chk("t3_coincident_rd", 32'(rd_cnt - base_rd), 32'd0);

        // 4: all four LTP at once, 3-cycle grant stalls, round-robin order 0..3
        do_reset();
        set_weight(0, 4'd3);
        set_weight(1, 4'd7);
        set_weight(2, 4'd9);
        set_weight(3, 4'd12);
        stall_len = 3;
        mark();
        pulse(4'b1111, 1'b0);
        for (int i = 0; i < NUM_PRE; i++) push_upd(i, 1'b1);
        pulse(4'b0000, 1'b1);
        wait_idle("t4_drain", 120);
        chk("t4_writes", 32'(wr_cnt - base_wr), 32'd4);
        chk("t4_upd", 32'(upd_cnt - base_upd), 32'd4);
        stall_len = 0;

        // 5a: LTP and LTD pending on synapse 3 cancel without any access
        do_reset();
        en = 1'b0;
        mark();
        pulse(4'b1000, 1'b0);
        pulse(4'b0000, 1'b1);
        pulse(4'b1000, 1'b0);
        repeat (2) cycle();
        en = 1'b1;
        repeat (12) cycle();
        chk("t5_cancel_rd", 32'(rd_cnt - base_rd), 32'd0);
        chk("t5_cancel_busy", 32'(busy), 32'd0);
        chk("t5_cancel_drop", 32'(drop_cnt), 32'd0);

        // 5b: a second post spike while ltp[1] is still pending is dropped
        en = 1'b0;
        do_reset();
        set_weight(1, 4'd9);
        mark();
        pulse(4'b0010, 1'b0);
        push_upd(1, 1'b1);
        pulse(4'b0000, 1'b1);
        pulse(4'b0000, 1'b1);
        cycle();
        chk("t5_drop", 32'(drop_cnt), 32'd1);
        chk("t5_idle_en0", 32'(rd_cnt - base_rd), 32'd0);
        en = 1'b1;
        wait_idle("t5_drain", 40);
        chk("t5_upd", 32'(upd_cnt - base_upd), 32'd1);

        // 6: reset while a write is stalled aborts it and discards pending work
        do_reset();
        set_weight(2, 4'd6);
        hold_wr = 1'b1;
        mark();
        pulse(4'b0100, 1'b0);
        push_upd(2, 1'b1);
        pulse(4'b0000, 1'b1);
        for (int i = 0; i < 40 && !(mem_req && mem_we); i++) cycle();
        chk("t6_in_wr", 32'(mem_req && mem_we), 32'd1);
        rst_n = 1'b0;
        sb_q.delete();
        cycle();
        chk("t6_req", 32'(mem_req), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_drop", 32'(drop_cnt), 32'd0);
        rst_n   = 1'b1;
        hold_wr = 1'b0;
        repeat (20) cycle();
        chk("t6_no_write", 32'(wr_cnt - base_wr), 32'd0);
        chk("t6_no_upd", 32'(upd_cnt - base_upd), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
